pipelined_variable_circular_shifter: RTL and testbench



---
 rtl/pipelined_variable_circular_shifter_if.sv | 28 ++
 rtl/pipelined_variable_circular_shifter.sv | 133 +++++++++++++
 tb/tb_pipelined_variable_circular_shifter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_variable_circular_shifter_if.sv
// Handshake bundle for the pipelined variable circular shifter.
// Upstream side:   up_valid, up_ready, up_data[N], up_amount[SW], up_dir
// Downstream side: down_valid, down_ready, down_data[N]
// slave  = view taken by the shifter; master = view taken by the environment.
interface pipelined_variable_circular_shifter_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned SW = $clog2(N);

    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [SW-1:0] up_amount;
    logic          up_dir;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;

    modport master (
        output up_valid, up_data, up_amount, up_dir, down_ready,
        input  up_ready, down_valid, down_data
    );

    modport slave (
        input  up_valid, up_data, up_amount, up_dir, down_ready,
        output up_ready, down_valid, down_data
    );
endinterface

// File: rtl/pipelined_variable_circular_shifter.sv
// Pipelined rotator: rotates an N-bit word left (dir=0) or right (dir=1) by a
// per-word amount, one registered barrel stage per amount bit (SW stages).
// Full valid/ready backpressure, 1 word/cycle, SW words in flight.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         pipelined_variable_circular_shifter_if.slave handshake bundle
//   xfer_count  16-bit count of downstream transfers, present only when
//               PIPELINED_VARIABLE_CIRCULAR_SHIFTER_XFER_COUNT_EN is defined
module pipelined_variable_circular_shifter #(
    parameter int unsigned N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef PIPELINED_VARIABLE_CIRCULAR_SHIFTER_XFER_COUNT_EN
    output logic [15:0] xfer_count,
`endif
    pipelined_variable_circular_shifter_if.slave bus
);
    localparam int unsigned SW = $clog2(N);

    // Stage registers; amt_q holds the not-yet-applied amount bits, LSB first.
    logic [SW-1:0]         valid_q, valid_d;
    logic [SW-1:0][N-1:0]  data_q,  data_d;
    logic [SW-1:0][SW-1:0] amt_q,   amt_d;
    logic [SW-1:0]         dir_q,   dir_d;

    // Inputs seen by each stage (stage 0 from upstream, stage k from k-1).
    logic [SW-1:0]         src_valid;
    logic [SW-1:0][N-1:0]  src_data;
    logic [SW-1:0][SW-1:0] src_amt;
    logic [SW-1:0]         src_dir;
    logic [SW-1:0][N-1:0]  rot_data;
    logic [SW-1:0]         stage_ready;

    // Last stage's amount/dir are carried for uniformity but never consumed.
    logic unused_tail;
    assign unused_tail = ^{amt_q[SW-1], dir_q[SW-1]};

    // Per-stage source selection and fixed 2^k rotation (wiring only).
    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int unsigned S = 1 << k;
        logic [N-1:0] rotl;
        logic [N-1:0] rotr;

        if (k == 0) begin : g_src_up
            assign src_valid[k] = bus.up_valid;
            assign src_data[k]  = bus.up_data;
            assign src_amt[k]   = bus.up_amount;
            assign src_dir[k]   = bus.up_dir;
        end else begin : g_src_prev
            assign src_valid[k] = valid_q[k-1];
            assign src_data[k]  = data_q[k-1];
            assign src_amt[k]   = amt_q[k-1];
            assign src_dir[k]   = dir_q[k-1];
        end

        assign rotl = {src_data[k][N-1-S:0], src_data[k][N-1:N-S]};
        assign rotr = {src_data[k][S-1:0],   src_data[k][N-1:S]};
        assign rot_data[k] = !src_amt[k][0] ? src_data[k]
                           : (src_dir[k] ? rotr : rotl);
    end

    // Ready chain from the output back: a stage loads when empty or draining.
    always_comb begin
        logic rdy;
        stage_ready = '0;
        rdy         = bus.down_ready;
        for (int k = SW - 1; k >= 0; k--) begin
            rdy            = !valid_q[k] || rdy;
            stage_ready[k] = rdy;
        end
    end

    // Next state: ready stages take their source (a bubble if source empty).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        amt_d   = amt_q;
        dir_d   = dir_q;
        for (int k = 0; k < SW; k++) begin
            if (stage_ready[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_d[k] = rot_data[k];
                    amt_d[k]  = src_amt[k] >> 1;
                    dir_d[k]  = src_dir[k];
                end
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            amt_q   <= '0;
            dir_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.up_ready   = stage_ready[0];
    assign bus.down_valid = valid_q[SW-1];
    assign bus.down_data  = data_q[SW-1];

`ifdef PIPELINED_VARIABLE_CIRCULAR_SHIFTER_XFER_COUNT_EN
    // Completed downstream transfers, wrapping at 16 bits.
    logic [15:0] xfer_count_q, xfer_count_d;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (valid_q[SW-1] && bus.down_ready) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_q <= 16'd0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_pipelined_variable_circular_shifter.sv
// Self-checking bench for pipelined_variable_circular_shifter (N=8).
// Optional counter checks are compiled when
// PIPELINED_VARIABLE_CIRCULAR_SHIFTER_XFER_COUNT_EN is defined.
module tb_pipelined_variable_circular_shifter;
    localparam int unsigned N  = 8;
    localparam int unsigned SW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipelined_variable_circular_shifter_if #(.N(N)) bus ();
`ifdef PIPELINED_VARIABLE_CIRCULAR_SHIFTER_XFER_COUNT_EN
    logic [15:0] xfer_count;
`endif

    pipelined_variable_circular_shifter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef PIPELINED_VARIABLE_CIRCULAR_SHIFTER_XFER_COUNT_EN
        .xfer_count (xfer_count),
`endif
        .bus        (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic       dir;
        logic [7:0] exp;
    } vec_t;

    int         tests    = 0;
    int         fails    = 0;
    int         tb_xfers = 0;
    logic [7:0] sb[$];
    bit         stall_prev = 1'b0;
    logic [7:0] prev_data  = '0;

    // Reference rotation: bit i moves to position i+a (left) or i-a (right), mod N.
    function automatic logic [7:0] rot_ref(input logic [7:0] d, input int a, input bit dir);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (!dir) r[(i + a) % 8] = d[i];
            else      r[i] = d[(i + a) % 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard and hold checks, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (!rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(bus.down_valid), 32'd1);
                chk("hold_data", 32'(bus.down_data), 32'(prev_data));
            end
            if (bus.down_valid && bus.down_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h, required no word", bus.down_data);
                end else begin
                    exp_w = sb.pop_front();
                    chk("sb_data", 32'(bus.down_data), 32'(exp_w));
                end
                tb_xfers++;
            end
            if (bus.up_valid && bus.up_ready)
                sb.push_back(rot_ref(bus.up_data, int'(bus.up_amount), bus.up_dir));
            stall_prev = bus.down_valid && !bus.down_ready;
            prev_data  = bus.down_data;
        end
    end

    task automatic apply_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        bus.up_valid   = 1'b0;
        bus.down_ready = 1'b0;
        sb.delete();
        tb_xfers = 0;
        #10;
        rst_n = 1'b1;
    endtask

    task automatic send_one(input vec_t v, input int idx);
        int lat;
        @(posedge clk); #1;
        bus.down_ready = 1'b1;
        bus.up_valid   = 1'b1;
        bus.up_data    = v.data;
        bus.up_amount  = v.amt;
        bus.up_dir     = v.dir;
        @(posedge clk); #1;
        bus.up_valid = 1'b0;
        lat = 1;
        while (!bus.down_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency_%0d", idx), 32'(lat), 32'd3);
        chk($sformatf("vec_data_%0d", idx), 32'(bus.down_data), 32'(v.exp));
        @(posedge clk); #1;
    endtask

    // Random traffic of n words, drained at the end; bounded by a cycle guard.
    task automatic run_stream(input int n, input int valid_pct, input int ready_pct);
        int sent  = 0;
        int guard = 0;
        while ((sent < n || sb.size() != 0) && guard < n * 20 + 100) begin
            @(posedge clk); #1;
            bus.up_valid   = (sent < n) && (int'($urandom_range(99)) < valid_pct);
            bus.up_data    = 8'($urandom);
            bus.up_amount  = 3'($urandom);
            bus.up_dir     = 1'($urandom);
            bus.down_ready = (sent >= n) || (int'($urandom_range(99)) < ready_pct);
            @(negedge clk); #1;
            if (bus.up_valid && bus.up_ready) sent++;
            guard++;
        end
        @(posedge clk); #1;
        bus.up_valid = 1'b0;
        chk("stream_sent", 32'(sent), 32'(n));
        chk("stream_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vec_t       vecs[9];
        logic [7:0] stream_exp[8];
        logic [7:0] w[5];
        logic [2:0] wa[5];
        logic       wd[5];
        int         accepted;
        int         rx_before;
        int         guard;
        int         seen;

        vecs[0] = '{data: 8'b10110101, amt: 3'd3, dir: 1'b0, exp: 8'b10101101};
        vecs[1] = '{data: 8'b10110101, amt: 3'd3, dir: 1'b1, exp: 8'b10110110};
        vecs[2] = '{data: 8'b10110101, amt: 3'd0, dir: 1'b0, exp: 8'b10110101};
        vecs[3] = '{data: 8'b10110101, amt: 3'd0, dir: 1'b1, exp: 8'b10110101};
        vecs[4] = '{data: 8'h01,       amt: 3'd7, dir: 1'b0, exp: 8'h80};
        vecs[5] = '{data: 8'h01,       amt: 3'd1, dir: 1'b1, exp: 8'h80};
        vecs[6] = '{data: 8'hF0,       amt: 3'd4, dir: 1'b0, exp: 8'h0F};
        vecs[7] = '{data: 8'h81,       amt: 3'd2, dir: 1'b1, exp: 8'h60};
        vecs[8] = '{data: 8'hC3,       amt: 3'd1, dir: 1'b0, exp: 8'h87};
        stream_exp = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

        bus.up_valid   = 1'b0;
        bus.up_data    = '0;
        bus.up_amount  = '0;
        bus.up_dir     = 1'b0;
        bus.down_ready = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_down_valid", 32'(bus.down_valid), 32'd0);
        chk("rst_up_ready", 32'(bus.up_ready), 32'd1);
        chk("rst_down_data", 32'(bus.down_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: latency and result
        for (int i = 0; i < 9; i++) send_one(vecs[i], i);

        // Back-to-back streaming, amounts 0..7
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            bus.down_ready = 1'b1;
            if (i >= 3 && i < 11) begin
                chk($sformatf("stream_valid_%0d", i - 3), 32'(bus.down_valid), 32'd1);
                chk($sformatf("stream_data_%0d", i - 3), 32'(bus.down_data), 32'(stream_exp[i - 3]));
            end
            if (i < 8) begin
                bus.up_valid  = 1'b1;
                bus.up_data   = 8'h80;
                bus.up_amount = 3'(i);
                bus.up_dir    = 1'b0;
                chk($sformatf("stream_up_ready_%0d", i), 32'(bus.up_ready), 32'd1);
            end else begin
                bus.up_valid = 1'b0;
            end
        end

        // Backpressure: 5 words into a 3-deep pipe with down_ready low
        for (int j = 0; j < 5; j++) begin
            w[j]  = 8'($urandom);
            wa[j] = 3'($urandom);
            wd[j] = 1'($urandom);
        end
        accepted  = 0;
        rx_before = tb_xfers;
        for (int s = 0; s < 8; s++) begin
            @(posedge clk); #1;
            bus.down_ready = 1'b0;
            bus.up_valid   = 1'b1;
            bus.up_data    = w[accepted];
            bus.up_amount  = wa[accepted];
            bus.up_dir     = wd[accepted];
            @(negedge clk); #1;
            if (bus.up_valid && bus.up_ready) accepted++;
        end
        chk("bp_accepted", 32'(accepted), 32'd3);
        chk("bp_up_ready", 32'(bus.up_ready), 32'd0);
        chk("bp_down_valid", 32'(bus.down_valid), 32'd1);
        chk("bp_head_data", 32'(bus.down_data), 32'(rot_ref(w[0], int'(wa[0]), wd[0])));
        guard = 0;
        while ((accepted < 5 || sb.size() != 0) && guard < 40) begin
            @(posedge clk); #1;
            bus.down_ready = 1'b1;
            if (accepted < 5) begin
                bus.up_valid  = 1'b1;
                bus.up_data   = w[accepted];
                bus.up_amount = wa[accepted];
                bus.up_dir    = wd[accepted];
            end else begin
                bus.up_valid = 1'b0;
            end
            @(negedge clk); #1;
            if (bus.up_valid && bus.up_ready) accepted++;
            guard++;
        end
        @(posedge clk); #1;
        bus.up_valid = 1'b0;
        chk("bp_all_accepted", 32'(accepted), 32'd5);
        chk("bp_received", 32'(tb_xfers - rx_before), 32'd5);

        // Reset mid-operation with two words in flight
        @(posedge clk); #1;
        bus.down_ready = 1'b0;
        bus.up_valid   = 1'b1;
        bus.up_data    = 8'hA5;
        bus.up_amount  = 3'd1;
        @(posedge clk); #1;
        bus.up_data    = 8'h3C;
        bus.up_amount  = 3'd2;
        @(posedge clk); #1;
        bus.up_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_pre_valid", 32'(bus.down_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.down_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.down_data), 32'd0);
        chk("mid_rst_up_ready", 32'(bus.up_ready), 32'd1);
        sb.delete();
        #3 rst_n = 1'b1;
        bus.down_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.down_valid) seen++;
        end
        chk("mid_no_stale", 32'(seen), 32'd0);
        chk("mid_up_ready", 32'(bus.up_ready), 32'd1);

        // Randomised traffic against the reference model
        run_stream(300, 70, 60);

`ifdef PIPELINED_VARIABLE_CIRCULAR_SHIFTER_XFER_COUNT_EN
        apply_reset();
        #1;
        chk("cnt_reset", 32'(xfer_count), 32'd0);
        run_stream(300, 60, 60);
        chk("cnt_300", 32'(xfer_count), 32'd300);
        chk("cnt_model", 32'(tb_xfers), 32'd300);
        run_stream(65536 - 300, 100, 100);
        chk("cnt_wrap", 32'(xfer_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
